// File: rtl/fifo_pkg.sv
// fifo_pkg: shared definitions for the sync_fifo family.
//   - state_e   : read-streamer control states
//   - width_for : counter/pointer width for a range of n values (minimum 1 bit)
//   - DEF_*     : default widths shared with sync_fifo
package fifo_pkg;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_BURST_LEN  = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    FLUSH  = 2'd2
  } state_e;

  // Bits needed to hold the values 0..n-1, never less than one bit.
  function automatic int width_for(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/stream_obuf.sv
// stream_obuf: register-based circular buffer feeding a valid/ready stream.
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   clr_i      synchronous clear of pointers and occupancy (wins over push/pop)
//   push_i     write wdata_i at the tail (ignored when full unless popping)
//   pop_i      drop the head entry (ignored when empty)
//   wdata_i    tail write data
//   rdata_o    head data
//   occ_o      number of valid entries
//   empty_o    occupancy is zero
//   full_o     occupancy equals DEPTH
module stream_obuf
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = 2,
  localparam int PTR_W     = width_for(DEPTH),
  localparam int OCC_W     = width_for(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr_i,
  input  logic                  push_i,
  input  logic                  pop_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic [OCC_W-1:0]      occ_o,
  output logic                  empty_o,
  output logic                  full_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]      occ_q, occ_d;
  logic                  do_push, do_pop;

  assign empty_o = (occ_q == '0);
  assign full_o  = (occ_q == OCC_W'(DEPTH));
  assign occ_o   = occ_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // A pop frees the head slot in the same cycle, so a full buffer still
  // accepts a push when it is also being popped.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  // DEPTH is a power of two, so pointers wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      occ_d    = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      occ_d = occ_q + 1'b1;
      else if (!do_push && do_pop) occ_d = occ_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  // Storage carries no reset; the top masks the head while the buffer is empty.
  always_ff @(posedge clk) begin
    if (do_push && !clr_i) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/fifo_read_streamer.sv
// fifo_read_streamer: read-side consumer of sync_fifo. Issues read_req,
// captures the 1-cycle-latency read data into stream_obuf and presents it
// as a valid/ready stream grouped into bursts of BURST_LEN beats.
// Ports:
//   clk, reset             clock, asynchronous active-high reset
//   flush                  synchronous flush, asserted together with the FIFO flush
//   enable                 allows leaving IDLE
//   fifo_empty/aempty      FIFO status
//   read_data/rdata_valid  FIFO read return, one cycle after read_req
//   read_req               FIFO read request
//   out_data/valid/ready   output stream, out_last marks the final beat of a burst
//   busy                   any state, buffered data or outstanding read
//   beats_sent             wrapping count of transferred beats
//   proto_err              sticky: unexpected return or buffer overflow
module fifo_read_streamer
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int OBUF_DEPTH = 2,
  parameter int BURST_LEN  = DEF_BURST_LEN,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  enable,
  input  logic                  fifo_empty,
  input  logic                  fifo_aempty,
  input  logic [DATA_WIDTH-1:0] read_data,
  input  logic                  rdata_valid,
  output logic                  read_req,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  beats_sent,
  output logic                  proto_err
);

  localparam int OCC_W  = width_for(OBUF_DEPTH + 1);
  localparam int SUM_W  = OCC_W + 1;
  localparam int BEAT_W = width_for(BURST_LEN);

  state_e                state_q, state_d;
  logic [OCC_W-1:0]      inflight_q, inflight_d;
  logic [BEAT_W-1:0]     beat_cnt_q, beat_cnt_d;
  logic [CNT_WIDTH-1:0]  beats_sent_q, beats_sent_d;
  logic                  proto_err_q, proto_err_d;

  logic [DATA_WIDTH-1:0] head_data;
  logic [OCC_W-1:0]      occ;
  logic                  obuf_empty, obuf_full;
  logic                  xfer, rv_expected, rv_unexpected, capture, overflow, push;
  logic [SUM_W-1:0]      load_sum;

  assign out_valid = ~obuf_empty;
  assign out_data  = out_valid ? head_data : '0;
  assign out_last  = out_valid & (beat_cnt_q == BEAT_W'(BURST_LEN - 1));
  assign xfer      = out_valid & out_ready;

  // Reserve a buffer slot for every outstanding read. Near empty only one
  // read may be outstanding, since fifo_empty lags a read by a cycle.
  assign load_sum = SUM_W'(occ) + SUM_W'(inflight_q);
  assign read_req = (state_q == ACTIVE) & ~flush & ~fifo_empty
                  & (load_sum < SUM_W'(OBUF_DEPTH))
                  & ((inflight_q == '0) | ~fifo_aempty);

  assign rv_expected   = rdata_valid & (inflight_q != '0);
  assign rv_unexpected = rdata_valid & (inflight_q == '0);
  // Returns that land during a flush are retired but their data is dropped.
  assign capture  = rv_expected & ~flush & (state_q != FLUSH);
  assign overflow = capture & obuf_full & ~xfer;
  assign push     = capture & ~overflow;

  assign busy       = (state_q != IDLE) | ~obuf_empty | (inflight_q != '0);
  assign beats_sent = beats_sent_q;
  assign proto_err  = proto_err_q;

  stream_obuf #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (OBUF_DEPTH)
  ) u_obuf (
    .clk     (clk),
    .rst     (reset),
    .clr_i   (flush),
    .push_i  (push),
    .pop_i   (xfer),
    .wdata_i (read_data),
    .rdata_o (head_data),
    .occ_o   (occ),
    .empty_o (obuf_empty),
    .full_o  (obuf_full)
  );

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = FLUSH;
    end else begin
      case (state_q)
        IDLE:    if (enable && !fifo_empty) state_d = ACTIVE;
        ACTIVE:  if (!enable && inflight_q == '0 && occ == '0) state_d = IDLE;
        FLUSH:   if (inflight_q == '0) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    inflight_d = inflight_q;
    if (read_req && !rv_expected)      inflight_d = inflight_q + 1'b1;
    else if (!read_req && rv_expected) inflight_d = inflight_q - 1'b1;

    beat_cnt_d = beat_cnt_q;
    if (flush) begin
      beat_cnt_d = '0;
    end else if (xfer) begin
      beat_cnt_d = (beat_cnt_q == BEAT_W'(BURST_LEN - 1)) ? '0 : beat_cnt_q + 1'b1;
    end

    beats_sent_d = beats_sent_q + CNT_WIDTH'(xfer);
    proto_err_d  = proto_err_q | rv_unexpected | overflow;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      inflight_q   <= '0;
      beat_cnt_q   <= '0;
      beats_sent_q <= '0;
      proto_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      inflight_q   <= inflight_d;
      beat_cnt_q   <= beat_cnt_d;
      beats_sent_q <= beats_sent_d;
      proto_err_q  <= proto_err_d;
    end
  end

endmodule
